trace_commit_buffer: RTL

- Sits directly downstream of writeback. Captures one tracer_bus_t record per retired instruction into a first-word-fall-through FIFO.
- Stamps each record with a retire sequence number and drains records over a valid/ready handshake to the simulation trace printer, which disassembles and logs them.
- Decouples the printer's back-pressure from the core. Overflow drops records instead of stalling the pipeline, and every drop is counted.

---
 rtl/trace_commit_buffer_if.sv | 37 +++
 rtl/trace_commit_buffer.sv | 83 ++++++++
 2 files changed

// File: rtl/trace_commit_buffer_if.sv
// Retire-record type plus the commit/drain bundle of the trace commit buffer.
// The package lives here so it is compiled ahead of every user of tracer_bus_t.
package trace_commit_buffer_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        rd_we;
  } tracer_bus_t;
endpackage

interface trace_commit_buffer_if
  import trace_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 32
);
  logic                     commit_valid;
  tracer_bus_t              commit_bus;
  logic                     out_valid;
  logic                     out_ready;
  tracer_bus_t              out_bus;
  logic [SEQ_W-1:0]         out_seq;
  logic [SEQ_W-1:0]         drop_cnt;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    input  commit_valid, commit_bus, out_ready,
    output out_valid, out_bus, out_seq, drop_cnt, level
  );

  modport slave (
    output commit_valid, commit_bus, out_ready,
    input  out_valid, out_bus, out_seq, drop_cnt, level
  );
endinterface

// File: rtl/trace_commit_buffer.sv
// Drop-on-overflow FIFO between writeback and the trace printer; stamps each
// retired record with a sequence number and presents a registered head.
module trace_commit_buffer
  import trace_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  trace_commit_buffer_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  tracer_bus_t      mem_bus [DEPTH];
  logic [SEQ_W-1:0] mem_seq [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0] level_q, level_next;
  logic [SEQ_W-1:0] seq_q, drop_q;
  tracer_bus_t      head_bus;
  logic [SEQ_W-1:0] head_seq;
  logic             valid, full, pop, push, drop, head_from_commit;

  assign valid = (level_q != '0);

  always_comb begin
    pop        = valid && bus.out_ready;
    full       = (level_q == FULL_LVL);
    push       = bus.commit_valid && (!full || pop);
    drop       = bus.commit_valid && full && !pop;
    rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_next = level_q;
    if (push && !pop)
      level_next = level_q + LVL_W'(1);
    else if (pop && !push)
      level_next = level_q - LVL_W'(1);
    // Next head is the incoming record only when it lands on the next read slot.
    head_from_commit = push && (wr_ptr == rd_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      head_bus <= '0;
      head_seq <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_next;
      level_q <= level_next;
      if (bus.commit_valid)
        seq_q <= seq_q + SEQ_W'(1);
      if (drop && (drop_q != '1))
        drop_q <= drop_q + SEQ_W'(1);
      if (level_next != '0) begin
        head_bus <= head_from_commit ? bus.commit_bus : mem_bus[rd_next];
        head_seq <= head_from_commit ? seq_q          : mem_seq[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_bus[wr_ptr] <= bus.commit_bus;
      mem_seq[wr_ptr] <= seq_q;
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_bus   = head_bus;
  assign bus.out_seq   = head_seq;
  assign bus.drop_cnt  = drop_q;
  assign bus.level     = level_q;

endmodule
